// File: rtl/demux_1x8_reg_n.sv
// Registered 1-to-8 demultiplexer with per-channel FULL flags, consume strobes and occupancy count.
// Optional overwrite mode: define DEMUX_DROP_EN to always accept and count overwrites in DROP_CNT.
module demux_1x8_reg_n #(
  parameter int unsigned BITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [BITS-1:0]     DIN,
  input  logic [2:0]          SEL,
  input  logic                DIN_VALID,
  output logic                DIN_READY,
  input  logic [7:0]          RD,
  output logic [8*BITS-1:0]   Q,
  output logic [7:0]          FULL,
  output logic [3:0]          OCUP,
  output logic [7:0]          DROP_CNT
);

  logic       wr_en;
  logic [7:0] wr_mask;
  logic [7:0] rd_hit;
  logic [7:0] full_nxt;
  logic       wr_new;
  logic [3:0] rd_cnt;

`ifdef DEMUX_DROP_EN
  assign DIN_READY = !reset;
`else
  assign DIN_READY = !reset && (!FULL[SEL] || RD[SEL]);
`endif

  assign wr_en    = DIN_VALID && DIN_READY;
  assign wr_mask  = wr_en ? (8'b0000_0001 << SEL) : '0;
  assign rd_hit   = RD & FULL;
  assign full_nxt = (FULL & ~rd_hit) | wr_mask;
  // A write adds occupancy whenever its channel is empty after this cycle's reads,
  // so a same-channel write+read nets to zero and OCUP tracks popcount(FULL).
  assign wr_new   = wr_en && (!FULL[SEL] || RD[SEL]);

  always_comb begin
    rd_cnt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      rd_cnt = rd_cnt + {3'b000, rd_hit[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Q    <= '0;
      FULL <= '0;
      OCUP <= '0;
    end else begin
      if (wr_en) begin
        Q[SEL*BITS +: BITS] <= DIN;
      end
      FULL <= full_nxt;
      OCUP <= OCUP + {3'b000, wr_new} - rd_cnt;
    end
  end

`ifdef DEMUX_DROP_EN
  logic overwrite;
  assign overwrite = wr_en && FULL[SEL] && !RD[SEL];

  always_ff @(posedge clock) begin
    if (reset) begin
      DROP_CNT <= '0;
    end else if (overwrite && (DROP_CNT != 8'hFF)) begin
      DROP_CNT <= DROP_CNT + 8'd1;
    end
  end
`else
  assign DROP_CNT = '0;
`endif

endmodule
